// File: rtl/fwd_scoreboard_unit_if.sv
// rtl/fwd_scoreboard_unit_if.sv - ID-stage bundle between decode/pipeline control and the forwarding scoreboard
// Purpose: groups the ID read ports, issue/load-response/control inputs and the forwarded outputs.
// Ports (master = pipeline side, slave = scoreboard):
//   rs_addr_i/port_en_i/rf_rdata_i : ID read ports
//   iss_*_i                        : instruction leaving ID and its EX result
//   ld_rsp_*_i                     : late load data return
//   hold_i/flush_i                 : pipeline freeze / kill
//   fwd_rdata_o/stall_o/stall_cnt_o: forwarded operands, load-use stall, stall statistics
interface fwd_scoreboard_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int NPORTS = 2,
  parameter int CNT_W  = 16
);
  logic [NPORTS*REG_AW-1:0] rs_addr_i;
  logic [NPORTS-1:0]        port_en_i;
  logic [NPORTS*XLEN-1:0]   rf_rdata_i;
  logic                     iss_we_i;
  logic [REG_AW-1:0]        iss_rd_i;
  logic                     iss_rdy_i;
  logic [XLEN-1:0]          iss_wdata_i;
  logic                     ld_rsp_vld_i;
  logic [REG_AW-1:0]        ld_rsp_rd_i;
  logic [XLEN-1:0]          ld_rsp_data_i;
  logic                     hold_i;
  logic                     flush_i;
  logic [NPORTS*XLEN-1:0]   fwd_rdata_o;
  logic                     stall_o;
  logic [CNT_W-1:0]         stall_cnt_o;

  modport master (
    output rs_addr_i, port_en_i, rf_rdata_i, iss_we_i, iss_rd_i, iss_rdy_i, iss_wdata_i,
    output ld_rsp_vld_i, ld_rsp_rd_i, ld_rsp_data_i, hold_i, flush_i,
    input  fwd_rdata_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  rs_addr_i, port_en_i, rf_rdata_i, iss_we_i, iss_rd_i, iss_rdy_i, iss_wdata_i,
    input  ld_rsp_vld_i, ld_rsp_rd_i, ld_rsp_data_i, hold_i, flush_i,
    output fwd_rdata_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/fwd_scoreboard_unit.sv
// rtl/fwd_scoreboard_unit.sv - in-flight register write tracker with operand forwarding and load-use stall
// Purpose: tracks NSTAGES producer entries (0 = EX, youngest) and forwards the youngest matching
//   result to each ID read port; stalls ID when that result is an outstanding load.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-low reset
//   bus  : fwd_scoreboard_unit_if.slave (read ports, issue, load response, hold/flush, outputs)
module fwd_scoreboard_unit #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NPORTS  = 2,
  parameter int NSTAGES = 3,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            rst,
  fwd_scoreboard_unit_if.slave bus
);

  // cap: entry issued last cycle as an ALU op; its result is on iss_wdata_i this cycle
  // and is latched into data at the coming edge.
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              rdy;
    logic              cap;
    logic [XLEN-1:0]   data;
  } ent_t;

  ent_t                 ent_q [NSTAGES];
  ent_t                 ent_d [NSTAGES];
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [NPORTS*XLEN-1:0] fwd_data;
  logic                 stall_any;
  logic                 stall;
  logic [NSTAGES-1:0]   fill_sel;

  // Per-port forwarding: first hit scanning from entry 0 is the youngest producer.
  always_comb begin
    logic [REG_AW-1:0] rs;
    logic [XLEN-1:0]   pdata;
    logic              found;
    stall_any = 1'b0;
    fwd_data  = '0;
    rs        = '0;
    pdata     = '0;
    found     = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      rs    = bus.rs_addr_i[p*REG_AW +: REG_AW];
      pdata = bus.rf_rdata_i[p*XLEN +: XLEN];
      found = 1'b0;
      for (int i = 0; i < NSTAGES; i++) begin
        if (!found && bus.port_en_i[p] && ent_q[i].vld &&
            (ent_q[i].rd != '0) && (ent_q[i].rd == rs)) begin
          found = 1'b1;
          if (ent_q[i].rdy) begin
            pdata = ent_q[i].cap ? bus.iss_wdata_i : ent_q[i].data;
          end else if (bus.ld_rsp_vld_i && (bus.ld_rsp_rd_i == rs)) begin
            pdata = bus.ld_rsp_data_i;
          end else begin
            stall_any = 1'b1;
          end
        end
      end
      fwd_data[p*XLEN +: XLEN] = pdata;
    end
  end

  assign stall           = rst & ~bus.flush_i & stall_any;
  assign bus.stall_o     = stall;
  assign bus.fwd_rdata_o = rst ? fwd_data : '0;
  assign bus.stall_cnt_o = stall_cnt_q;

  // Next tracker state: capture and fill act on current positions, then the shift
  // carries them to their post-shift slot. Flush overrides everything.
  always_comb begin
    logic sel_found;
    sel_found = 1'b0;
    fill_sel  = '0;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      if (!sel_found && bus.ld_rsp_vld_i && ent_q[i].vld && !ent_q[i].rdy &&
          (ent_q[i].rd == bus.ld_rsp_rd_i)) begin
        fill_sel[i] = 1'b1;
        sel_found   = 1'b1;
      end
    end

    for (int i = 0; i < NSTAGES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].cap) begin
        ent_d[i].data = bus.iss_wdata_i;
        ent_d[i].cap  = 1'b0;
      end
      if (fill_sel[i]) begin
        ent_d[i].rdy  = 1'b1;
        ent_d[i].data = bus.ld_rsp_data_i;
      end
    end

    if (!bus.hold_i) begin
      for (int i = NSTAGES - 1; i > 0; i--) begin
        ent_d[i] = ent_d[i-1];
      end
      ent_d[0] = '0;
      if (!stall) begin
        ent_d[0].vld = bus.iss_we_i;
        ent_d[0].rd  = bus.iss_rd_i;
        ent_d[0].rdy = bus.iss_rdy_i;
        ent_d[0].cap = bus.iss_we_i & bus.iss_rdy_i;
      end
    end

    if (bus.flush_i) begin
      for (int i = 0; i < NSTAGES; i++) begin
        ent_d[i].vld = 1'b0;
        ent_d[i].cap = 1'b0;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NSTAGES; i++) begin
        ent_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      ent_q       <= ent_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
